fp4_complex_quantizer: RTL and testbench
========================================

Name: fp4_complex_quantizer

Overview:
- Streaming encoder that converts signed fixed-point complex samples into packed complex FP4: real in out_data[7:4], imag in out_data[3:0].
- FP4 word is [sign][exp:2][mant:1]. Value is (-1)^s × 1.m × 2^(exp-1) for exp≠00. Zero is 4'b0000.
- Sits in front of the FFT butterfly datapath. It is the producer of the FP4 operands that the complex add/sub units consume.
- Two-stage valid/ready pipeline with a per-sample block-scaling shift and saturating statistics counters.

Parameters:
- IN_W, 8, width of each signed two's-complement input component (Q(IN_W-2).2, i.e. FRAC=2 fixed). Legal range 4..16.
- CNT_W, 16, width of the saturation and underflow event counters.

Ports:
- clk  input  1  clock; all logic on the rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input sample valid
- in_ready  output  1  block can accept a sample this cycle
- in_re  input  IN_W  real component, signed, 2 fractional bits
- in_im  input  IN_W  imag component, signed, 2 fractional bits
- in_shift  input  3  right-shift applied to both components before quantization
- out_valid  output  1  encoded sample valid
- out_ready  input  1  downstream accepts the sample
- out_data  output  8  {fp4_re, fp4_im}
- out_sat  output  2  {re, im}: the component was clipped to max finite
- out_uflow  output  2  {re, im}: a nonzero component was flushed to zero
- clr_stats  input  1  synchronous clear of both counters
- sat_count  output  CNT_W  accepted clipped components, saturating at all-ones
- uflow_count  output  CNT_W  accepted flushed components, saturating at all-ones

Behaviour:
- Reset, asynchronous: all valid bits, out_data, out_sat, out_uflow and both counters go to 0. in_ready is 1 after reset.
- Transfer rule: a transfer happens when valid and ready are both high on the same edge.
- Pipeline: S1 registers sign, magnitude and shift. S2 quantizes and holds the output register.
- Latency is exactly 2 cycles from input transfer to out_valid when there is no backpressure.
- Throughput is 1 sample per cycle with no bubbles.
- Stage advance: each stage advances when its successor is empty or is transferring. in_ready = !s1_valid || s2 can accept.
- While out_valid is high and out_ready is low, out_data and all flags hold stable.
- Magnitude: |x| is computed at IN_W+1 bits so that the most-negative input is exact. Sign is x<0.
- Shift: q = |x| >> in_shift, a logical floor on the magnitude, in quarter units.
- Quantization: round-to-nearest, ties to even mantissa, with explicit thresholds on q:
  - q ≤ 1 → 0000. Sign is dropped; there is no negative zero.
  - 2..5 → 1.0 (s,01,0)
  - 6 → 1.5 (s,01,1)
  - 7..10 → 2.0 (s,10,0)
  - 11..13 → 3.0 (s,10,1)
  - q ≥ 14 → 4.0 (s,11,0)
- Encoding s,11,1 (infinity) is never produced.
- Flags:
  - sat = q > 16 (value > 4.0).
  - uflow = q == 1, i.e. a nonzero value after the shift that encodes to zero. A shift that alone reduces the magnitude to 0 is not counted.
- Counters: each output transfer adds popcount(out_sat) and popcount(out_uflow), i.e. 0, 1 or 2, saturating at 2^CNT_W-1.
- clr_stats has priority over a simultaneous increment; the counter reads 0 on the next cycle.
- Reset mid-stream discards all in-flight samples. No partial output is emitted.

Decomposition:
- Package fp4_pkg:
  - FP4 field widths and FRAC=2
  - constants FP4_ZERO=4'b0000, FP4_MAX=4'b0110, FP4_INF=4'b0111
  - threshold constants Q_ZERO_MAX=1, Q_ONE_MAX=5, Q_ONEHALF=6, Q_TWO_MAX=10, Q_THREE_MAX=13, Q_SAT_GT=16
  - typedef for the packed complex FP4 word
- Sub-module fp4_quantize: purely combinational, one lane. Inputs are sign and magnitude; outputs are fp4, sat and uflow. It is instantiated twice, for re and im.

Test Plan:
- in_re=6 (1.5), in_im=-14 (-3.5), shift 0 → out_data=8'b0011_1110 two cycles later, flags 0.
- in_re=5 (1.25 tie), in_im=10 (2.5 tie), shift 0 → 8'b0010_0100. Confirms ties go to even mantissa.
- in_re=-128 (IN_W=8), in_im=1, shift 0 → 8'b1110_0000, out_sat=2'b10, out_uflow=2'b01. sat_count and uflow_count each reach 1 after the transfer.
- in_re=64, shift 3 (q=8) → 0100. in_re=3, shift 2 (q=0) → 0000 with no uflow flag.
- Burst of 6 samples with out_ready low for cycles 3-5:
  - no loss and no duplication
  - order preserved
  - out_data stable while stalled
  - in_ready drops once both stages are full
- Counters:
  - preload to all-ones-1, then two sat components in one transfer → saturates at all-ones
  - clr_stats on the same cycle as an increment → 0
  - assert rst_n low mid-burst → out_valid is 0 immediately and the counters read 0

Source files
------------

// File: rtl/fp4_pkg.sv
// Shared FP4 encoding constants, quantization thresholds (in quarter units of the
// input magnitude) and the packed complex FP4 word type.
package fp4_pkg;

    localparam int FRAC       = 2;
    localparam int FP4_EXP_W  = 2;
    localparam int FP4_MANT_W = 1;
    localparam int FP4_W      = 1 + FP4_EXP_W + FP4_MANT_W;

    localparam logic [FP4_W-1:0] FP4_ZERO = 4'b0000;
    localparam logic [FP4_W-1:0] FP4_MAX  = 4'b0110;
    localparam logic [FP4_W-1:0] FP4_INF  = 4'b0111;

    // Round-to-nearest, ties-to-even boundaries on the shifted magnitude q.
    localparam int unsigned Q_ZERO_MAX  = 1;
    localparam int unsigned Q_ONE_MAX   = 5;
    localparam int unsigned Q_ONEHALF   = 6;
    localparam int unsigned Q_TWO_MAX   = 10;
    localparam int unsigned Q_THREE_MAX = 13;
    localparam int unsigned Q_SAT_GT    = 4 << FRAC;

    typedef logic [FP4_W-1:0] fp4_t;

    typedef struct packed {
        fp4_t re;
        fp4_t im;
    } fp4_cplx_t;

endpackage

// File: rtl/fp4_quantize.sv
// One combinational quantizer lane: sign + shifted magnitude (quarter units) to FP4,
// with clip and flush-to-zero indications.
module fp4_quantize
    import fp4_pkg::*;
#(
    parameter int MAG_W = 9
) (
    input  logic             comp_sign,
    input  logic [MAG_W-1:0] mag,
    output fp4_t             fp4,
    output logic             sat,
    output logic             uflow
);

    // Exponent/mantissa bits only; sign is attached by the caller.
    function automatic logic [2:0] round_code(input logic [31:0] q);
        if (q <= Q_ZERO_MAX)       return FP4_ZERO[2:0];
        else if (q <= Q_ONE_MAX)   return 3'b010;
        else if (q == Q_ONEHALF)   return 3'b011;
        else if (q <= Q_TWO_MAX)   return 3'b100;
        else if (q <= Q_THREE_MAX) return 3'b101;
        else                       return FP4_MAX[2:0];
    endfunction

    logic [31:0] q32;
    logic [2:0]  code;

    always_comb begin
        q32   = 32'(mag);
        code  = round_code(q32);
        // No negative zero: a flushed value always encodes as all zeros.
        fp4   = (code == FP4_ZERO[2:0]) ? FP4_ZERO : {comp_sign, code};
        sat   = (q32 > Q_SAT_GT);
        uflow = (q32 != 32'd0) && (code == FP4_ZERO[2:0]);
    end

    always_comb assert (fp4[2:0] != FP4_INF[2:0]);

endmodule

// File: rtl/fp4_complex_quantizer.sv
// Two-stage valid/ready encoder from signed Q(IN_W-2).2 complex samples to packed
// complex FP4, with per-sample right shift and saturating clip/flush counters.
module fp4_complex_quantizer
    import fp4_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] in_re,
    input  logic signed [IN_W-1:0] in_im,
    input  logic [2:0]             in_shift,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_data,
    output logic [1:0]             out_sat,
    output logic [1:0]             out_uflow,
    input  logic                   clr_stats,
    output logic [CNT_W-1:0]       sat_count,
    output logic [CNT_W-1:0]       uflow_count
);

    localparam int MAG_W = IN_W + 1;

    // One extra bit so that the most-negative input has an exact magnitude.
    function automatic logic [MAG_W-1:0] abs_mag(input logic signed [IN_W-1:0] x);
        logic [MAG_W-1:0] ext;
        ext = {x[IN_W-1], x};
        return x[IN_W-1] ? (~ext + MAG_W'(1)) : ext;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[1]} + {1'b0, v[0]};
    endfunction

    logic             s2_ready;
    logic             load_p1;
    logic             load_p2;
    logic             out_fire;

    logic             vld_p1;
    logic             sign_re_p1;
    logic             sign_im_p1;
    logic [MAG_W-1:0] mag_re_p1;
    logic [MAG_W-1:0] mag_im_p1;
    logic [2:0]       shift_p1;
    logic [MAG_W-1:0] q_re_p1;
    logic [MAG_W-1:0] q_im_p1;

    fp4_t             fp4_re;
    fp4_t             fp4_im;
    logic             sat_re;
    logic             sat_im;
    logic             uflow_re;
    logic             uflow_im;

    logic             vld_p2;
    fp4_cplx_t        data_p2;
    logic [1:0]       sat_p2;
    logic [1:0]       uflow_p2;
    logic [CNT_W-1:0] sat_cnt;
    logic [CNT_W-1:0] uflow_cnt;

    assign s2_ready = !vld_p2 || out_ready;
    assign in_ready = !vld_p1 || s2_ready;
    assign load_p1  = in_valid && in_ready;
    assign load_p2  = vld_p1 && s2_ready;
    assign out_fire = vld_p2 && out_ready;

    // Stage 1: sign, magnitude and shift amount
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (in_ready) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (load_p1) begin
            sign_re_p1 <= in_re[IN_W-1];
            sign_im_p1 <= in_im[IN_W-1];
            mag_re_p1  <= abs_mag(in_re);
            mag_im_p1  <= abs_mag(in_im);
            shift_p1   <= in_shift;
        end
    end

    // Stage 2: shift, quantize, hold for the consumer
    assign q_re_p1 = mag_re_p1 >> shift_p1;
    assign q_im_p1 = mag_im_p1 >> shift_p1;

    fp4_quantize #(.MAG_W(MAG_W)) u_quant_re (
        .comp_sign (sign_re_p1),
        .mag       (q_re_p1),
        .fp4       (fp4_re),
        .sat       (sat_re),
        .uflow     (uflow_re)
    );

    fp4_quantize #(.MAG_W(MAG_W)) u_quant_im (
        .comp_sign (sign_im_p1),
        .mag       (q_im_p1),
        .fp4       (fp4_im),
        .sat       (sat_im),
        .uflow     (uflow_im)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2   <= 1'b0;
            data_p2  <= '0;
            sat_p2   <= '0;
            uflow_p2 <= '0;
        end else begin
            if (s2_ready) begin
                vld_p2 <= vld_p1;
            end
            if (load_p2) begin
                data_p2  <= {fp4_re, fp4_im};
                sat_p2   <= {sat_re, sat_im};
                uflow_p2 <= {uflow_re, uflow_im};
            end
        end
    end

    // Statistics count only components that actually leave the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt   <= '0;
            uflow_cnt <= '0;
        end else if (clr_stats) begin
            sat_cnt   <= '0;
            uflow_cnt <= '0;
        end else if (out_fire) begin
            sat_cnt   <= sat_add(sat_cnt, popcount2(sat_p2));
            uflow_cnt <= sat_add(uflow_cnt, popcount2(uflow_p2));
        end
    end

    assign out_valid   = vld_p2;
    assign out_data    = data_p2;
    assign out_sat     = sat_p2;
    assign out_uflow   = uflow_p2;
    assign sat_count   = sat_cnt;
    assign uflow_count = uflow_cnt;

endmodule

// File: tb/tb_fp4_complex_quantizer.sv
// Randomized and directed bench for fp4_complex_quantizer against a nearest-value
// FP4 reference model and a queue-based scoreboard.
module tb_fp4_complex_quantizer;

    localparam int IN_W  = 8;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct {
        logic [7:0] data;
        logic [1:0] sat;
        logic [1:0] uf;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic signed [IN_W-1:0] in_re;
    logic signed [IN_W-1:0] in_im;
    logic [2:0]             in_shift;
    logic                   out_valid;
    logic                   out_ready;
    logic [7:0]             out_data;
    logic [1:0]             out_sat;
    logic [1:0]             out_uflow;
    logic                   clr_stats;
    logic [CNT_W-1:0]       sat_count;
    logic [CNT_W-1:0]       uflow_count;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    int   m_sat = 0;
    int   m_uf  = 0;

    fp4_complex_quantizer #(.IN_W(IN_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_re       (in_re),
        .in_im       (in_im),
        .in_shift    (in_shift),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sat     (out_sat),
        .out_uflow   (out_uflow),
        .clr_stats   (clr_stats),
        .sat_count   (sat_count),
        .uflow_count (uflow_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Nearest representable value among {0,1,1.5,2,3,4} (quarter units), ties to the
    // even mantissa; the 0/1.0 tie resolves upward.
    function automatic void ref_lane(input int x, input int sh,
                                     output logic [3:0] code, output logic sat, output logic uf);
        int         cand[6] = '{0, 4, 6, 8, 12, 16};
        bit         modd[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0] enc[6]  = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
        int mag, q, best, bd, d;
        mag  = (x < 0) ? -x : x;
        q    = mag >> sh;
        best = 0;
        bd   = q;
        for (int i = 1; i < 6; i++) begin
            d = (q > cand[i]) ? q - cand[i] : cand[i] - q;
            if (d < bd || (d == bd && !modd[i] && (modd[best] || cand[i] > cand[best]))) begin
                best = i;
                bd   = d;
            end
        end
        code = (best == 0) ? 4'b0000 : {(x < 0), enc[best]};
        sat  = (q > 16);
        uf   = (q != 0) && (best == 0);
    endfunction

    function automatic exp_t ref_sample(input int re, input int im, input int sh);
        exp_t e;
        logic [3:0] cr, ci;
        logic sr, si, ur, ui;
        ref_lane(re, sh, cr, sr, ur);
        ref_lane(im, sh, ci, si, ui);
        e.data = {cr, ci};
        e.sat  = {sr, si};
        e.uf   = {ur, ui};
        return e;
    endfunction

    // Scoreboard and counter model, sampled on the falling edge.
    initial begin
        exp_t e;
        int inc_s, inc_u;
        logic prev_stall = 1'b0;
        logic [11:0] prev_word = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                m_sat = 0;
                m_uf  = 0;
                prev_stall = 1'b0;
            end else begin
                check("sat_count", 32'(sat_count), 32'(m_sat));
                check("uflow_count", 32'(uflow_count), 32'(m_uf));
                if (prev_stall)
                    check("stall_hold", 32'({out_valid, out_data, out_sat, out_uflow}), 32'({1'b1, prev_word}));
                inc_s = 0;
                inc_u = 0;
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_out", 32'(1), 32'(0));
                    end else begin
                        e = exp_q[0];
                        check("out_data", 32'(out_data), 32'(e.data));
                        check("out_sat", 32'(out_sat), 32'(e.sat));
                        check("out_uflow", 32'(out_uflow), 32'(e.uf));
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            inc_s = int'(e.sat[0]) + int'(e.sat[1]);
                            inc_u = int'(e.uf[0]) + int'(e.uf[1]);
                        end
                    end
                end
                if (clr_stats) begin
                    m_sat = 0;
                    m_uf  = 0;
                end else begin
                    m_sat = (m_sat + inc_s > CMAX) ? CMAX : m_sat + inc_s;
                    m_uf  = (m_uf + inc_u > CMAX) ? CMAX : m_uf + inc_u;
                end
                prev_stall = out_valid && !out_ready;
                prev_word  = {out_data, out_sat, out_uflow};
                if (in_valid && in_ready)
                    exp_q.push_back(ref_sample(int'(in_re), int'(in_im), int'(in_shift)));
            end
        end
    end

    task automatic send(input int re, input int im, input int sh);
        int n = 0;
        in_re    = IN_W'(re);
        in_im    = IN_W'(im);
        in_shift = 3'(sh);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 32'(0), 32'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] d,
                              input logic [1:0] s, input logic [1:0] u);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'(1));
        check({tag, "_data"}, 32'(out_data), 32'(d));
        check({tag, "_sat"}, 32'(out_sat), 32'(s));
        check({tag, "_uflow"}, 32'(out_uflow), 32'(u));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        in_shift  = '0;
        out_ready = 1'b1;
        clr_stats = 1'b0;

        #12;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_flags", 32'({out_sat, out_uflow}), 32'(0));
        check("rst_counts", 32'({sat_count, uflow_count}), 32'(0));
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(6, -14, 0);
        @(negedge clk);
        check("lat_cycle1", 32'(out_valid), 32'(0));
        @(negedge clk);
        check("lat_cycle2", 32'(out_valid), 32'(1));
        check("basic_data", 32'(out_data), 32'(8'b0011_1110));
        check("basic_flags", 32'({out_sat, out_uflow}), 32'(0));
        @(posedge clk);
        #1;

        send(5, 10, 0);
        expect_out("tie_even", 8'b0010_0100, 2'b00, 2'b00);
        send(-128, 1, 0);
        expect_out("min_neg", 8'b1110_0000, 2'b10, 2'b01);
        check("sat_count_1", 32'(sat_count), 32'(1));
        check("uflow_count_1", 32'(uflow_count), 32'(1));
        send(64, 0, 3);
        expect_out("shift_q8", 8'b0100_0000, 2'b00, 2'b00);
        send(3, -2, 2);
        expect_out("shift_to_zero", 8'b0000_0000, 2'b00, 2'b00);

        // Burst of six with the consumer stalled for three cycles.
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 60)) - 30, 0);
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                check("burst_in_ready_low", 32'(in_ready), 32'(0));
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Counter saturation and clear priority.
        reset_dut();
        for (int i = 0; i < (CMAX - 1) / 2; i++) send(-128, -128, 0);
        drain();
        check("sat_cnt_preload", 32'(sat_count), 32'(CMAX - 1));
        send(-128, 127, 0);
        drain();
        check("sat_cnt_clip", 32'(sat_count), 32'(CMAX));
        send(-128, 0, 0);
        drain();
        check("sat_cnt_hold", 32'(sat_count), 32'(CMAX));
        out_ready = 1'b0;
        send(-128, 1, 0);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        clr_stats = 1'b1;
        @(posedge clk);
        #1 clr_stats = 1'b0;
        @(negedge clk);
        check("clr_priority_sat", 32'(sat_count), 32'(0));
        check("clr_priority_uflow", 32'(uflow_count), 32'(0));
        @(posedge clk);
        #1;

        // Reset with samples in flight.
        send(-128, 1, 0);
        drain();
        out_ready = 1'b0;
        send(20, 30, 0);
        send(40, -50, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_sat_count", 32'(sat_count), 32'(0));
        check("midrst_uflow_count", 32'(uflow_count), 32'(0));
        check("midrst_out_data", 32'(out_data), 32'(0));
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_no_output", 32'(out_valid), 32'(0));
        @(posedge clk);
        #1;

        // Randomized traffic with random backpressure and occasional clears.
        for (int c = 0; c < 800; c++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 1) == 0) begin
                in_re = IN_W'($urandom);
                in_im = IN_W'($urandom);
            end else begin
                in_re = IN_W'(int'($urandom_range(0, 40)) - 20);
                in_im = IN_W'(int'($urandom_range(0, 40)) - 20);
            end
            in_shift  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
            out_ready = ($urandom_range(0, 3) != 0);
            clr_stats = ($urandom_range(0, 59) == 0);
            @(posedge clk);
            #1;
        end
        clr_stats = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
